// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: upstream stage of the 64-tap serial-MAC FIR.
// Buffers samples in a small FIFO behind a valid/ready handshake and presents
// each sample to the FIR as a TAPS-cycle burst of fir_ready with fir_sig held
// constant for the entire burst.
//
// Handshake: a sample is transferred on a rising clk edge where
// s_valid & s_ready are both high. s_ready is registered and reflects
// (fifo_level != FIFO_DEPTH), so the FIFO can never overflow.
//
// Optional build macro: FEEDER_ZERO_FILL_EN
//   defined   - at frame end with an empty FIFO, load fir_sig=0 and keep
//               bursting, so fir_ready stays high after the first sample
//               and the FIR delay line flushes with zeros.
//   undefined - at frame end with an empty FIFO, return to IDLE and hold
//               fir_sig at its last value.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = RUN) for checkers.
module fir_sample_feeder #(
    parameter int WIDTH      = 18,
    parameter int TAPS       = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [WIDTH-1:0]       s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic signed [WIDTH-1:0]       fir_sig,
    output logic                          fir_ready,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [0:0]                    dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic signed [WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic                    s_ready_q, s_ready_d;
    logic [0:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [WIDTH-1:0] sig_q, sig_d;
    logic                    fir_ready_q, fir_ready_d;
    logic                    frame_done_q, frame_done_d;

    logic push;
    logic pop;

    assign push = s_valid & s_ready_q;

    // Frame sequencing: decide when to pop the FIFO head into the hold register.
    always_comb begin
        pop     = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    sig_d   = mem_q[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_TAP) begin
                    // Frame closes this edge; a push landing on this same
                    // edge is not yet counted in level_q.
                    cnt_d = '0;
                    if (level_q != '0) begin
                        pop   = 1'b1;
                        sig_d = mem_q[rd_ptr_q];
                    end else begin
`ifdef FEEDER_ZERO_FILL_EN
                        sig_d = '0;
`else
                        state_d = IDLE;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FIFO bookkeeping and registered output flags derived from next state.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        level_d      = level_q + LW'(push) - LW'(pop);
        s_ready_d    = (level_d != FULL_LVL);
        fir_ready_d  = (state_d == RUN);
        frame_done_d = (state_d == RUN) && (cnt_d == LAST_TAP);
    end

    // Sample storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            s_ready_q    <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            sig_q        <= '0;
            fir_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            s_ready_q    <= s_ready_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sig_q        <= sig_d;
            fir_ready_q  <= fir_ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign fir_sig    = sig_q;
    assign fir_ready  = fir_ready_q;
    assign frame_done = frame_done_q;
    assign fifo_level = level_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: directed steps in one initial block, a
// negedge monitor that pops the expected sample of each frame from exp_q and
// checks fir_sig stability, frame_done position and burst lengths.
// Honours FEEDER_ZERO_FILL_EN when the build defines it.
module tb_fir_sample_feeder;

    localparam int WIDTH = 18;
    localparam int TAPS  = 64;
    localparam int DEPTH = 8;

    logic                    clk;
    logic                    rst_n;
    logic signed [WIDTH-1:0] s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic signed [WIDTH-1:0] fir_sig;
    logic                    fir_ready;
    logic                    frame_done;
    logic [3:0]              fifo_level;
    logic [0:0]              dbg_state;

    fir_sample_feeder #(.WIDTH(WIDTH), .TAPS(TAPS), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .fir_sig    (fir_sig),
        .fir_ready  (fir_ready),
        .frame_done (frame_done),
        .fifo_level (fifo_level),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: frame contents, frame_done position, burst lengths, FIFO peak.
    int               tap_cnt    = 0;
    int               run_len    = 0;
    int               last_run   = 0;
    int               peak_level = 0;
    bit               saw_full   = 1'b0;
    logic [WIDTH-1:0] cur_exp    = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            tap_cnt = 0;
            run_len = 0;
        end else begin
            if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
            if (s_valid && !s_ready && int'(fifo_level) == DEPTH) saw_full = 1'b1;
            if (fir_ready) begin
                run_len++;
                if (tap_cnt == 0) begin
`ifdef FEEDER_ZERO_FILL_EN
                    if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
                    else cur_exp = '0;
`else
                    check("sb_frame_has_sample", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
`endif
                end
                check("fir_sig_frame", fir_sig, $signed(cur_exp));
                tap_cnt++;
                check("frame_done_pos", frame_done, (tap_cnt == TAPS));
                if (tap_cnt == TAPS) tap_cnt = 0;
            end else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
                check("no_partial_frame", tap_cnt, 0);
                check("frame_done_idle", frame_done, 0);
                tap_cnt = 0;
            end
        end
    end

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        int g;
        s_data  = v[WIDTH-1:0];
        s_valid = 1'b1;
        g = 0;
        while (!s_ready && g < 500) begin
            step();
            g++;
        end
        check("push_wait_ready", (g < 500), 1);
        step();
        exp_q.push_back(v[WIDTH-1:0]);
        s_valid = 1'b0;
    endtask

    task automatic wait_fall(input int budget);
        int g;
        g = 0;
        while (fir_ready && g < budget) begin
            step();
            g++;
        end
        check("wait_fir_ready_low", (g < budget), 1);
    endtask

    // Directed sequence.
    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) step();

        check("rst_fifo_level", fifo_level, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_fir_sig", fir_sig, 0);
        check("rst_fir_ready", fir_ready, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_state", dbg_state, 0);

        rst_n = 1'b1;
        check("s_ready_before_edge", s_ready, 0);
        step();
        check("s_ready_after_reset", s_ready, 1);

`ifdef FEEDER_ZERO_FILL_EN
        // Single sample, then continuous zero-filled frames.
        push(100);
        step();
        check("zf_first_ready", fir_ready, 1);
        check("zf_first_sig", fir_sig, 100);
        repeat (63) step();
        check("zf_frame1_done", frame_done, 1);
        step();
        check("zf_frame2_ready", fir_ready, 1);
        check("zf_frame2_sig", fir_sig, 0);
        repeat (10) step();
        push(50);
        repeat (52) step();
        check("zf_frame2_last", frame_done, 1);
        step();
        check("zf_frame3_ready", fir_ready, 1);
        check("zf_frame3_sig", fir_sig, 50);
        repeat (64) step();
        check("zf_frame4_sig", fir_sig, 0);
        check("zf_state_run", dbg_state, 1);
`else
        // Single sample of 1000: 2-cycle latency, one 64-cycle frame.
        push(1000);
        check("t1_ready_latency1", fir_ready, 0);
        check("t1_level_after_push", fifo_level, 1);
        step();
        check("t1_ready_latency2", fir_ready, 1);
        check("t1_sig", fir_sig, 1000);
        check("t1_level_after_pop", fifo_level, 0);
        repeat (63) step();
        check("t1_frame_done", frame_done, 1);
        check("t1_ready_last", fir_ready, 1);
        step();
        check("t1_ready_drop", fir_ready, 0);
        check("t1_done_drop", frame_done, 0);
        check("t1_sig_hold", fir_sig, 1000);
        step();
        check("t1_burst_len", last_run, 64);

        // Three back-to-back samples: 192 contiguous ready cycles, peak level 2.
        peak_level = 0;
        push(5);
        push(-7);
        push(9);
        wait_fall(1000);
        step();
        check("t2_burst_len", last_run, 192);
        check("t2_peak_level", peak_level, 2);
        check("t2_sb_empty", exp_q.size(), 0);

        // Sustained s_valid with FIR busy: FIFO fills, nothing lost or duplicated.
        peak_level = 0;
        saw_full   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            push(int'($urandom_range(0, 262143)) - 131072);
        end
        wait_fall(1500);
        step();
        check("t3_peak_level", peak_level, 8);
        check("t3_saw_full", saw_full, 1);
        check("t3_burst_len", last_run, 12 * 64);
        check("t3_sb_empty", exp_q.size(), 0);

        // Reset at counter 30 with four samples buffered.
        push(11);
        push(12);
        push(13);
        push(14);
        push(15);
        repeat (27) step();
        check("t4_level_before_rst", fifo_level, 4);
        check("t4_ready_before_rst", fir_ready, 1);
        rst_n = 1'b0;
        exp_q.delete();
        step();
        rst_n = 1'b1;
        check("t4_ready_after_rst", fir_ready, 0);
        check("t4_level_after_rst", fifo_level, 0);
        check("t4_sig_after_rst", fir_sig, 0);
        check("t4_state_after_rst", dbg_state, 0);
        step();
        check("t4_s_ready_back", s_ready, 1);
        push(77);
        step();
        check("t4_restart_sig", fir_sig, 77);
        wait_fall(200);
        step();
        check("t4_restart_len", last_run, 64);

        // Push landing on the closing edge of the last frame with an empty FIFO.
        push(300);
        step();
        repeat (63) step();
        check("t5_last_tap", frame_done, 1);
        s_data  = 18'sd301;
        s_valid = 1'b1;
        check("t5_s_ready", s_ready, 1);
        step();
        exp_q.push_back(18'd301);
        s_valid = 1'b0;
        check("t5_idle_gap", fir_ready, 0);
        check("t5_level_gap", fifo_level, 1);
        step();
        check("t5_new_frame", fir_ready, 1);
        check("t5_new_sig", fir_sig, 301);
        wait_fall(200);
        step();
        check("t5_new_len", last_run, 64);
        check("t5_sb_empty", exp_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
